// File: rtl/nv_nvdla_pdp_reg_group_ctrl.sv
// Ping-pong register-group scheduler for the PDP datapath.
// It owns the per-group op_en flags, the hardware consumer pointer and the
// per-group status fields. It launches the datapath on the consumer group and
// swaps groups when a layer completes.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   producer       : software producer pointer; readback only, does not affect scheduling
//   op_en_trigger  : per-group write strobe to D_OP_ENABLE
//   op_en_wr_data  : write data bit that accompanies the strobe
//   dp2reg_done    : datapath finished its current layer
//   consumer       : group currently owned by hardware
//   status_0/1     : 0 idle, 1 running, 2 pending (combinational from flops)
//   d_op_en        : per-group op_en flags
//   reg2dp_op_en   : launch level to the datapath
//   done_intr      : one-cycle completion pulse, one bit per group
//   wr_err         : op_en write to a busy group was dropped
//   done_err       : done arrived while the datapath was not launched
module nv_nvdla_pdp_reg_group_ctrl #(
  parameter int unsigned OP_EN_GAP = 2,
  parameter int unsigned GAP_W     = 4
) (
  input  logic       nvdla_core_clk,
  input  logic       nvdla_core_rstn,
  input  logic       producer,
  input  logic [1:0] op_en_trigger,
  input  logic       op_en_wr_data,
  input  logic       dp2reg_done,
  output logic       consumer,
  output logic [1:0] status_0,
  output logic [1:0] status_1,
  output logic [1:0] d_op_en,
  output logic       reg2dp_op_en,
  output logic [1:0] done_intr,
  output logic       wr_err,
  output logic       done_err
);

  localparam int unsigned NGRP = 2;

  logic             consumer_q, consumer_d;
  logic [NGRP-1:0]  d_op_en_q, d_op_en_d;
  logic             op_en_q, op_en_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [NGRP-1:0]  done_intr_q, done_intr_d;
  logic             wr_err_q, wr_err_d;
  logic             done_err_q, done_err_d;

  logic             done_ok_c;
  logic [NGRP-1:0]  wr_set_c;
  logic [NGRP-1:0]  wr_busy_c;

  // The producer pointer only shares the readback path with the consumer pointer.
  logic unused_producer;
  assign unused_producer = producer;

  // Next-state logic for pointer, flags, gap counter and pulses.
  always_comb begin
    consumer_d  = consumer_q;
    d_op_en_d   = d_op_en_q;
    gap_cnt_d   = gap_cnt_q;
    done_intr_d = '0;
    wr_err_d    = 1'b0;
    done_err_d  = 1'b0;

    done_ok_c = dp2reg_done & op_en_q;

    // Set-only writes; a group that is already enabled (including the consumer
    // in its done cycle) rejects the write with an error pulse.
    wr_set_c  = op_en_trigger & {NGRP{op_en_wr_data}} & ~d_op_en_q;
    wr_busy_c = op_en_trigger & {NGRP{op_en_wr_data}} &  d_op_en_q;

    d_op_en_d = d_op_en_q | wr_set_c;
    wr_err_d  = |wr_busy_c;

    if (done_ok_c) begin
      d_op_en_d[consumer_q]   = 1'b0;
      done_intr_d[consumer_q] = 1'b1;
      consumer_d              = ~consumer_q;
      gap_cnt_d               = GAP_W'(OP_EN_GAP);
    end else if (gap_cnt_q != '0) begin
      gap_cnt_d = gap_cnt_q - GAP_W'(1);
    end

    done_err_d = dp2reg_done & ~op_en_q;

    // Launch level looks at current flops; a done pulse forces it low immediately.
    op_en_d = (gap_cnt_q == '0) & d_op_en_q[consumer_q] & ~dp2reg_done;
  end

  // State registers.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      consumer_q  <= 1'b0;
      d_op_en_q   <= '0;
      op_en_q     <= 1'b0;
      gap_cnt_q   <= '0;
      done_intr_q <= '0;
      wr_err_q    <= 1'b0;
      done_err_q  <= 1'b0;
    end else begin
      consumer_q  <= consumer_d;
      d_op_en_q   <= d_op_en_d;
      op_en_q     <= op_en_d;
      gap_cnt_q   <= gap_cnt_d;
      done_intr_q <= done_intr_d;
      wr_err_q    <= wr_err_d;
      done_err_q  <= done_err_d;
    end
  end

  // Status decode: idle when not enabled, running when owned by hardware, else pending.
  always_comb begin
    status_0 = 2'd0;
    status_1 = 2'd0;
    if (d_op_en_q[0]) status_0 = (consumer_q == 1'b0) ? 2'd1 : 2'd2;
    if (d_op_en_q[1]) status_1 = (consumer_q == 1'b1) ? 2'd1 : 2'd2;
  end

  assign consumer     = consumer_q;
  assign d_op_en      = d_op_en_q;
  assign reg2dp_op_en = op_en_q;
  assign done_intr    = done_intr_q;
  assign wr_err       = wr_err_q;
  assign done_err     = done_err_q;

endmodule

// File: tb/tb_nv_nvdla_pdp_reg_group_ctrl.sv
// Directed bench for the PDP ping-pong register-group scheduler.
module tb_nv_nvdla_pdp_reg_group_ctrl;

  logic       clk;
  logic       rstn;
  logic       producer;
  logic [1:0] trig;
  logic       wr_data;
  logic       done;
  logic       consumer;
  logic [1:0] status_0;
  logic [1:0] status_1;
  logic [1:0] d_op_en;
  logic       op_en;
  logic [1:0] done_intr;
  logic       wr_err;
  logic       done_err;

  int n_pass;
  int n_chk;

  nv_nvdla_pdp_reg_group_ctrl #(.OP_EN_GAP(2), .GAP_W(4)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .producer        (producer),
    .op_en_trigger   (trig),
    .op_en_wr_data   (wr_data),
    .dp2reg_done     (done),
    .consumer        (consumer),
    .status_0        (status_0),
    .status_1        (status_1),
    .d_op_en         (d_op_en),
    .reg2dp_op_en    (op_en),
    .done_intr       (done_intr),
    .wr_err          (wr_err),
    .done_err        (done_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one rising edge, then settle 1ns so outputs are sampled off-edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    trig    = 2'b00;
    wr_data = 1'b0;
    done    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cons"},   8'(consumer),  8'h0);
    check({tag, "_dopen"},  8'(d_op_en),   8'h0);
    check({tag, "_open"},   8'(op_en),     8'h0);
    check({tag, "_intr"},   8'(done_intr), 8'h0);
    check({tag, "_wrerr"},  8'(wr_err),    8'h0);
    check({tag, "_dnerr"},  8'(done_err),  8'h0);
    check({tag, "_st0"},    8'(status_0),  8'h0);
    check({tag, "_st1"},    8'(status_1),  8'h0);
  endtask

  initial begin
    n_pass   = 0;
    n_chk    = 0;
    producer = 1'b0;
    idle_in();
    rstn = 1'b0;
    #12;
    check_all_zero("rst");
    rstn = 1'b1;
    step();

    // Idle launch of group 0.
    trig = 2'b01; wr_data = 1'b1;
    step(); idle_in();
    check("launch_dopen", 8'(d_op_en),  8'h1);
    check("launch_st0",   8'(status_0), 8'h1);
    check("launch_open0", 8'(op_en),    8'h0);
    step();
    check("launch_open1", 8'(op_en),    8'h1);

    // Queue group 1 behind running group 0.
    producer = 1'b1;
    trig = 2'b10; wr_data = 1'b1;
    step(); idle_in();
    check("queue_dopen", 8'(d_op_en),  8'h3);
    check("queue_st1",   8'(status_1), 8'h2);
    check("queue_wrerr", 8'(wr_err),   8'h0);

    // Write to busy group 0 is rejected; data 0 is a no-op.
    trig = 2'b01; wr_data = 1'b1;
    step(); idle_in();
    check("busy_wrerr", 8'(wr_err),  8'h1);
    check("busy_dopen", 8'(d_op_en), 8'h3);
    step();
    check("busy_wrerr_clr", 8'(wr_err), 8'h0);
    trig = 2'b01; wr_data = 1'b0;
    step(); idle_in();
    check("data0_wrerr", 8'(wr_err),  8'h0);
    check("data0_dopen", 8'(d_op_en), 8'h3);

    // Done on group 0: swap to group 1 with a two-cycle gap.
    done = 1'b1;
    step(); idle_in();
    check("swap_cons",  8'(consumer),  8'h1);
    check("swap_intr",  8'(done_intr), 8'h1);
    check("swap_dopen", 8'(d_op_en),   8'h2);
    check("swap_st0",   8'(status_0),  8'h0);
    check("swap_st1",   8'(status_1),  8'h1);
    check("gap_m1",     8'(op_en),     8'h0);
    step();
    check("gap_m2",      8'(op_en),     8'h0);
    check("swap_intr_c", 8'(done_intr), 8'h0);
    step();
    check("gap_m3", 8'(op_en), 8'h0);
    step();
    check("gap_m4", 8'(op_en), 8'h1);

    // Done on group 1 wraps the consumer back to 0.
    done = 1'b1;
    step(); idle_in();
    check("wrap_cons",  8'(consumer),  8'h0);
    check("wrap_intr",  8'(done_intr), 8'h2);
    check("wrap_dopen", 8'(d_op_en),   8'h0);
    repeat (4) step();
    check("wrap_idle_open", 8'(op_en), 8'h0);

    // Done with nothing launched.
    done = 1'b1;
    step(); idle_in();
    check("dnerr_pulse", 8'(done_err),  8'h1);
    check("dnerr_cons",  8'(consumer),  8'h0);
    check("dnerr_intr",  8'(done_intr), 8'h0);
    step();
    check("dnerr_clr", 8'(done_err), 8'h0);

    // Done and trigger to the consumer group in the same cycle.
    trig = 2'b01; wr_data = 1'b1;
    step(); idle_in();
    step();
    check("same_run", 8'(op_en), 8'h1);
    done = 1'b1; trig = 2'b01; wr_data = 1'b1;
    step(); idle_in();
    check("same_wrerr", 8'(wr_err),    8'h1);
    check("same_dopen", 8'(d_op_en),   8'h0);
    check("same_cons",  8'(consumer),  8'h1);
    check("same_intr",  8'(done_intr), 8'h1);
    repeat (4) step();

    // Done and trigger to the other group in the same cycle: accepted, launches after gap.
    trig = 2'b10; wr_data = 1'b1;
    step(); idle_in();
    step();
    check("other_run", 8'(op_en), 8'h1);
    done = 1'b1; trig = 2'b01; wr_data = 1'b1;
    step(); idle_in();
    check("other_wrerr", 8'(wr_err),    8'h0);
    check("other_dopen", 8'(d_op_en),   8'h1);
    check("other_cons",  8'(consumer),  8'h0);
    check("other_intr",  8'(done_intr), 8'h2);
    check("other_st0",   8'(status_0),  8'h1);
    step();
    check("other_m2", 8'(op_en), 8'h0);
    step();
    check("other_m3", 8'(op_en), 8'h0);
    step();
    check("other_m4", 8'(op_en), 8'h1);

    // Queue group 1, then reset mid-layer.
    trig = 2'b10; wr_data = 1'b1;
    step(); idle_in();
    check("pre_rst_dopen", 8'(d_op_en), 8'h3);
    #2 rstn = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    check_all_zero("midrst_edge");
    #3 rstn = 1'b1;
    step();

    // Both groups written in one cycle.
    trig = 2'b11; wr_data = 1'b1;
    step(); idle_in();
    check("dual_dopen", 8'(d_op_en),  8'h3);
    check("dual_st0",   8'(status_0), 8'h1);
    check("dual_st1",   8'(status_1), 8'h2);
    step();
    check("dual_open",  8'(op_en),    8'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
